// File: rtl/sargantana_icache_pkg.sv
// ---------------------------------------------------------------------------
// sargantana_icache_pkg
// Shared types and constants for the Sargantana i-cache blocks.
//   icache_flush_state_t : state encoding of the flush/invalidation sequencer
//   ICACHE_N_SETS        : number of sets in the i-cache valid arrays
//   ICACHE_N_WAY         : number of ways (one valid-bit clear enable per way)
// ---------------------------------------------------------------------------
package sargantana_icache_pkg;

    localparam int ICACHE_N_SETS = 64;
    localparam int ICACHE_N_WAY  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        WALK  = 2'd2,
        DONE  = 2'd3
    } icache_flush_state_t;

endpackage

// File: rtl/sargantana_icache_flush_seq_if.sv
// ---------------------------------------------------------------------------
// sargantana_icache_flush_seq_if
// Bundles the flush handshake, ctrl fill status, valid-array clear port and
// single-set invalidate handshake of the i-cache flush sequencer.
//   master : the sequencer side (drives flush_ack_o, flush_done_o, busy_o,
//            inval_we_o, inval_idx_o, line_inval_ack_o)
//   slave  : the ctrl / requester side (drives flush_req_i, fill_busy_i,
//            fill_wr_i, line_inval_req_i, line_inval_idx_i)
// The _i/_o suffixes are relative to the sequencer.
// ---------------------------------------------------------------------------
interface sargantana_icache_flush_seq_if #(
    parameter int ICACHE_N_WAY  = sargantana_icache_pkg::ICACHE_N_WAY,
    parameter int ICACHE_N_SETS = sargantana_icache_pkg::ICACHE_N_SETS
);
    localparam int IDX_W = $clog2(ICACHE_N_SETS);

    logic                    flush_req_i;
    logic                    flush_ack_o;
    logic                    flush_done_o;
    logic                    busy_o;
    logic                    fill_busy_i;
    logic                    fill_wr_i;
    logic [ICACHE_N_WAY-1:0] inval_we_o;
    logic [IDX_W-1:0]        inval_idx_o;
    logic                    line_inval_req_i;
    logic [IDX_W-1:0]        line_inval_idx_i;
    logic                    line_inval_ack_o;

    modport master (
        input  flush_req_i, fill_busy_i, fill_wr_i, line_inval_req_i, line_inval_idx_i,
        output flush_ack_o, flush_done_o, busy_o, inval_we_o, inval_idx_o, line_inval_ack_o
    );

    modport slave (
        output flush_req_i, fill_busy_i, fill_wr_i, line_inval_req_i, line_inval_idx_i,
        input  flush_ack_o, flush_done_o, busy_o, inval_we_o, inval_idx_o, line_inval_ack_o
    );

endinterface

// File: rtl/sargantana_icache_flush_seq.sv
// ---------------------------------------------------------------------------
// sargantana_icache_flush_seq
// Invalidation sequencer for the i-cache valid arrays. A flush request waits
// for any outstanding IFILL to drain, then clears all way valid bits of every
// set, one set per cycle, and pulses flush_done_o once the last set is done.
// Array fill writes from ctrl (fill_wr_i) always win over walker writes.
//
// Ports:
//   clk_i   : clock
//   rstn_i  : asynchronous reset, active-low
//   bus     : sargantana_icache_flush_seq_if.master
//             flush_req_i/flush_ack_o  flush request, acked combinationally
//             flush_done_o             1-cycle pulse after the last set
//             busy_o                   sequencer not IDLE
//             fill_busy_i / fill_wr_i  ctrl IFILL outstanding / array write
//             inval_we_o / inval_idx_o valid-bit clear enables and set index
//             line_inval_*             single-set invalidate handshake
//
// Configuration:
//   SARG_ICACHE_LINE_INVAL_EN : when defined, single-set invalidates are
//   served in IDLE; otherwise line_inval_* inputs are ignored and
//   line_inval_ack_o is tied to 0.
// ---------------------------------------------------------------------------
module sargantana_icache_flush_seq #(
    parameter int ICACHE_N_WAY  = sargantana_icache_pkg::ICACHE_N_WAY,
    parameter int ICACHE_N_SETS = sargantana_icache_pkg::ICACHE_N_SETS
) (
    input logic                           clk_i,
    input logic                           rstn_i,
    sargantana_icache_flush_seq_if.master bus
);
    import sargantana_icache_pkg::*;

    localparam int               IDX_W    = $clog2(ICACHE_N_SETS);
    localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(ICACHE_N_SETS - 1);

    icache_flush_state_t     state_q, state_d;
    logic [IDX_W-1:0]        set_cnt_q, set_cnt_d;

    logic                    flush_ack;
    logic                    flush_done;
    logic                    busy;
    logic [ICACHE_N_WAY-1:0] inval_we;
    logic [IDX_W-1:0]        inval_idx;
    logic                    line_ack;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= IDLE;
            set_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            set_cnt_q <= set_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        set_cnt_d  = set_cnt_q;
        flush_ack  = 1'b0;
        flush_done = 1'b0;
        busy       = 1'b1;
        inval_we   = '0;
        inval_idx  = '0;
        line_ack   = 1'b0;

        // Requests are accepted in every state; the state decides what the
        // request means. Gating with rstn_i keeps every output low while the
        // asynchronous reset is held.
        flush_ack = bus.flush_req_i & rstn_i;

        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (bus.flush_req_i) begin
                    state_d = DRAIN;
                end
`ifdef SARG_ICACHE_LINE_INVAL_EN
                else if (bus.line_inval_req_i && !bus.fill_wr_i && rstn_i) begin
                    inval_we  = '1;
                    inval_idx = bus.line_inval_idx_i;
                    line_ack  = 1'b1;
                end
`endif
            end

            // A request arriving here is simply absorbed: the walk that
            // follows covers it.
            DRAIN: begin
                if (!bus.fill_busy_i) begin
                    state_d   = WALK;
                    set_cnt_d = '0;
                end
            end

            // A ctrl fill write stalls the walker without advancing the
            // counter, so no set is ever skipped. A new flush request lets
            // the current write go out but restarts the walk from set 0,
            // which also takes precedence over finishing on the last set.
            WALK: begin
                if (!bus.fill_wr_i) begin
                    inval_we  = '1;
                    inval_idx = set_cnt_q;
                    set_cnt_d = set_cnt_q + 1'b1;
                    if (set_cnt_q == LAST_SET) begin
                        state_d = DONE;
                    end
                end
                if (bus.flush_req_i) begin
                    set_cnt_d = '0;
                    state_d   = WALK;
                end
            end

            DONE: begin
                flush_done = 1'b1;
                state_d    = bus.flush_req_i ? DRAIN : IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifndef SARG_ICACHE_LINE_INVAL_EN
    logic unused_line_inval;
    assign unused_line_inval = ^{bus.line_inval_req_i, bus.line_inval_idx_i};
`endif

    assign bus.flush_ack_o      = flush_ack;
    assign bus.flush_done_o     = flush_done;
    assign bus.busy_o           = busy;
    assign bus.inval_we_o       = inval_we;
    assign bus.inval_idx_o      = inval_idx;
    assign bus.line_inval_ack_o = line_ack;

endmodule

// File: tb/tb_sargantana_icache_flush_seq.sv
// ---------------------------------------------------------------------------
// tb_sargantana_icache_flush_seq
// Directed self-checking bench for the i-cache flush sequencer
// (ICACHE_N_SETS=64, ICACHE_N_WAY=4). Inputs change on the falling edge and
// outputs are sampled 1 time unit later, away from the rising edge.
// ---------------------------------------------------------------------------
module tb_sargantana_icache_flush_seq;

    localparam int N_WAY  = 4;
    localparam int N_SETS = 64;

    logic clk_i;
    logic rstn_i;

    int checks_total;
    int checks_passed;

    sargantana_icache_flush_seq_if #(.ICACHE_N_WAY(N_WAY), .ICACHE_N_SETS(N_SETS)) bus ();

    sargantana_icache_flush_seq #(
        .ICACHE_N_WAY  (N_WAY),
        .ICACHE_N_SETS (N_SETS)
    ) dut (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .bus    (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks_total++;
        if (observed !== expected) begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, observed, expected, $time);
        end else begin
            checks_passed++;
        end
    endtask

    // Drive one cycle's inputs on the falling edge, then let the
    // combinational outputs settle before the caller samples them.
    task automatic applyStimulus(input logic req, input logic fbusy, input logic fwr,
                                 input logic lreq, input logic [5:0] lidx);
        @(negedge clk_i);
        bus.flush_req_i      = req;
        bus.fill_busy_i      = fbusy;
        bus.fill_wr_i        = fwr;
        bus.line_inval_req_i = lreq;
        bus.line_inval_idx_i = lidx;
        #1;
    endtask

    // Steps the sequencer from DRAIN (fill_busy_i low) until flush_done_o
    // is seen. A bench-side expected index follows the walk; an optional
    // fill-write stall is applied at set stallAt and an optional re-request
    // at set restartAt. Every protocol violation bumps nErr.
    task automatic runWalk(input int startCyc, input int stallAt, input int stallLen,
                           input int restartAt, output int nWrites, output int nErr,
                           output int nDone, output int doneCyc);
        int  expIdx;
        int  stallLeft;
        bit  restarted;
        bit  req;
        bit  fwr;
        expIdx    = 0;
        stallLeft = stallLen;
        restarted = 1'b0;
        nWrites   = 0;
        nErr      = 0;
        nDone     = 0;
        doneCyc   = -1;
        for (int cyc = startCyc; cyc < startCyc + 400; cyc++) begin
            fwr = (expIdx == stallAt) && (stallLeft > 0);
            req = !restarted && !fwr && (expIdx == restartAt);
            applyStimulus(req, 1'b0, fwr, 1'b0, 6'd0);
            if (fwr) stallLeft--;
            if (req) begin
                restarted = 1'b1;
                if (bus.flush_ack_o !== 1'b1) nErr++;
            end
            if (bus.busy_o !== 1'b1) nErr++;
            if (fwr && bus.inval_we_o !== 4'h0) nErr++;
            if (bus.inval_we_o === 4'hF) begin
                if (bus.inval_idx_o !== expIdx[5:0]) nErr++;
                nWrites++;
                expIdx = req ? 0 : expIdx + 1;
            end else if (bus.inval_we_o !== 4'h0 || bus.inval_idx_o !== 6'd0) begin
                nErr++;
            end
            if (bus.flush_done_o === 1'b1) begin
                nDone++;
                doneCyc = cyc;
                if (bus.inval_we_o !== 4'h0) nErr++;
                break;
            end
        end
    endtask

    initial begin
        int nWrites;
        int nErr;
        int nDone;
        int doneCyc;
        int cnt;

        checks_total  = 0;
        checks_passed = 0;
        bus.flush_req_i      = 1'b0;
        bus.fill_busy_i      = 1'b0;
        bus.fill_wr_i        = 1'b0;
        bus.line_inval_req_i = 1'b0;
        bus.line_inval_idx_i = '0;
        rstn_i = 1'b0;

        // Reset state
        #12;
        checkOutput("reset_busy", 32'(bus.busy_o), 32'd0);
        checkOutput("reset_done", 32'(bus.flush_done_o), 32'd0);
        checkOutput("reset_we", 32'(bus.inval_we_o), 32'd0);
        checkOutput("reset_idx", 32'(bus.inval_idx_o), 32'd0);
        @(negedge clk_i);
        rstn_i = 1'b1;

        // 1: plain flush, no stalls
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
        checkOutput("t1_ack", 32'(bus.flush_ack_o), 32'd1);
        checkOutput("t1_busy_idle", 32'(bus.busy_o), 32'd0);
        checkOutput("t1_we_idle", 32'(bus.inval_we_o), 32'd0);
        runWalk(1, -1, 0, -1, nWrites, nErr, nDone, doneCyc);
        checkOutput("t1_writes", 32'(nWrites), 32'd64);
        checkOutput("t1_errors", 32'(nErr), 32'd0);
        checkOutput("t1_done_cycle", 32'(doneCyc), 32'd66);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
        checkOutput("t1_busy_after", 32'(bus.busy_o), 32'd0);
        checkOutput("t1_done_after", 32'(bus.flush_done_o), 32'd0);

        // 2: IFILL outstanding for 10 cycles at the request
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 6'd0);
        checkOutput("t2_ack", 32'(bus.flush_ack_o), 32'd1);
        cnt = 0;
        for (int i = 1; i < 10; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 6'd0);
            if (bus.inval_we_o !== 4'h0 || bus.busy_o !== 1'b1) cnt++;
        end
        checkOutput("t2_drain_quiet", 32'(cnt), 32'd0);
        runWalk(10, -1, 0, -1, nWrites, nErr, nDone, doneCyc);
        checkOutput("t2_writes", 32'(nWrites), 32'd64);
        checkOutput("t2_errors", 32'(nErr), 32'd0);
        checkOutput("t2_done_cycle", 32'(doneCyc), 32'd75);

        // 3: ctrl fill writes stall the walk at set 5 for 3 cycles
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
        runWalk(1, 5, 3, -1, nWrites, nErr, nDone, doneCyc);
        checkOutput("t3_writes", 32'(nWrites), 32'd64);
        checkOutput("t3_errors", 32'(nErr), 32'd0);
        checkOutput("t3_done_cycle", 32'(doneCyc), 32'd69);

        // 4: re-request at set 40 restarts the walk, one done only
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
        runWalk(1, -1, 0, 40, nWrites, nErr, nDone, doneCyc);
        checkOutput("t4_writes", 32'(nWrites), 32'd105);
        checkOutput("t4_errors", 32'(nErr), 32'd0);
        checkOutput("t4_done_count", 32'(nDone), 32'd1);
        checkOutput("t4_done_cycle", 32'(doneCyc), 32'd107);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
        checkOutput("t4_idle_after", 32'(bus.busy_o), 32'd0);

        // 5: asynchronous reset at set 20 abandons the walk
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
        for (int i = 0; i < 21; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
        checkOutput("t5_pre_idx", 32'(bus.inval_idx_o), 32'd19);
        @(negedge clk_i);
        bus.flush_req_i = 1'b1;
        rstn_i = 1'b0;
        #1;
        checkOutput("t5_rst_we", 32'(bus.inval_we_o), 32'd0);
        checkOutput("t5_rst_idx", 32'(bus.inval_idx_o), 32'd0);
        checkOutput("t5_rst_busy", 32'(bus.busy_o), 32'd0);
        checkOutput("t5_rst_ack", 32'(bus.flush_ack_o), 32'd0);
        checkOutput("t5_rst_done", 32'(bus.flush_done_o), 32'd0);
        @(negedge clk_i);
        bus.flush_req_i = 1'b0;
        rstn_i = 1'b1;
        cnt = 0;
        for (int i = 0; i < 80; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
            if (bus.flush_done_o !== 1'b0 || bus.inval_we_o !== 4'h0 || bus.busy_o !== 1'b0) cnt++;
        end
        checkOutput("t5_quiet_after", 32'(cnt), 32'd0);

        // 6: single-set invalidate in IDLE
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 6'd9);
`ifdef SARG_ICACHE_LINE_INVAL_EN
        checkOutput("t6_line_ack", 32'(bus.line_inval_ack_o), 32'd1);
        checkOutput("t6_line_we", 32'(bus.inval_we_o), 32'hF);
        checkOutput("t6_line_idx", 32'(bus.inval_idx_o), 32'd9);
        checkOutput("t6_line_busy", 32'(bus.busy_o), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 6'd9);
        checkOutput("t6_fillwr_ack", 32'(bus.line_inval_ack_o), 32'd0);
        checkOutput("t6_fillwr_we", 32'(bus.inval_we_o), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 6'd9);
        checkOutput("t6_prio_flush_ack", 32'(bus.flush_ack_o), 32'd1);
        checkOutput("t6_prio_line_ack", 32'(bus.line_inval_ack_o), 32'd0);
        checkOutput("t6_prio_we", 32'(bus.inval_we_o), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 6'd9);
        checkOutput("t6_drain_line_ack", 32'(bus.line_inval_ack_o), 32'd0);
        runWalk(2, -1, 0, -1, nWrites, nErr, nDone, doneCyc);
        checkOutput("t6_walk_writes", 32'(nWrites), 32'd64);
        checkOutput("t6_walk_done_cycle", 32'(doneCyc), 32'd66);
`else
        checkOutput("t6_line_ack_off", 32'(bus.line_inval_ack_o), 32'd0);
        checkOutput("t6_line_we_off", 32'(bus.inval_we_o), 32'd0);
        checkOutput("t6_line_idx_off", 32'(bus.inval_idx_o), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
        checkOutput("t6_still_idle", 32'(bus.busy_o), 32'd0);
`endif

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
